bcd_convert_seq: RTL and testbench

BCD_CONVERT_SEQ -- requirements
Module: bcd_convert_seq

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd_convert_seq.sv | 106 ++++++++++
 tb/tb_bcd_convert_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter control states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of one BCD digit.
    localparam int DIGIT_W = 4;

    // Digits at or above this value get +3 before each double-dabble shift.
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is >= 5.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);

    // A digit >= 5 would become >= 10 after doubling; +3 makes the shift carry correctly.
    assign adj = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Optional two's-complement input: magnitude is converted, sign reported separately.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int W      = 12,
    parameter int D      = 4,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         bin,
    output logic                 busy,
    output logic                 done,
    output logic [DIGIT_W*D-1:0] bcd,
    output logic                 neg,
    output logic                 overflow
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = DIGIT_W * D;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sreg;
    logic [BW-1:0]   work;
    logic            ovf_acc;
    logic            neg_acc;

    logic            bin_neg;
    logic [W-1:0]    mag;
    logic [BW-1:0]   adj_work;
    logic [BW-1:0]   next_work;
    logic            next_ovf;

    // Sign and magnitude of the operand; -2^(W-1) negates to 2^(W-1), which fits unsigned in W bits.
    assign bin_neg = (SIGNED != 0) && bin[W-1];
    assign mag     = bin_neg ? (~bin + W'(1)) : bin;

    // One add-3 cell per working digit.
    genvar g;
    generate
        for (g = 0; g < D; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .digit (work[g*DIGIT_W +: DIGIT_W]),
                .adj   (adj_work[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Result of one iteration: shift corrected digits left, pull in the operand MSB.
    // Anything leaving the top digit means the value does not fit in D digits.
    assign next_work = {adj_work[BW-2:0], sreg[W-1]};
    assign next_ovf  = ovf_acc | adj_work[BW-1];

    // Control FSM, datapath registers and registered outputs.
    // NOTE: every register here uses <= so all of them see pre-edge values of each other;
    // the working registers are reset too, so an aborted conversion leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sreg     <= '0;
            work     <= '0;
            ovf_acc  <= 1'b0;
            neg_acc  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            neg      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg    <= mag;
                        work    <= '0;
                        ovf_acc <= 1'b0;
                        neg_acc <= bin_neg;
                        cnt     <= CW'(W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg    <= sreg << 1;
                    work    <= next_work;
                    ovf_acc <= next_ovf;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd      <= next_work;
                        overflow <= next_ovf;
                        neg      <= neg_acc;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Testbench for bcd_convert_seq: three instances (unsigned D=4, unsigned D=3, signed D=4)
// compared against a decimal-arithmetic reference model.
module tb_bcd_convert_seq;

    localparam int W = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [11:0] bin_v [3];
    logic [2:0]  busy_v, done_v, neg_v, ovf_v;
    logic [15:0] bcd_u;
    logic [11:0] bcd_o;
    logic [15:0] bcd_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // sel 0: unsigned, 4 digits
    bcd_convert_seq #(.W(12), .D(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start_v[0]), .bin(bin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd_u), .neg(neg_v[0]), .overflow(ovf_v[0])
    );

    // sel 1: unsigned, 3 digits
    bcd_convert_seq #(.W(12), .D(3), .SIGNED(0)) dut_o (
        .clk(clk), .rst(rst), .start(start_v[1]), .bin(bin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd_o), .neg(neg_v[1]), .overflow(ovf_v[1])
    );

    // sel 2: signed, 4 digits
    bcd_convert_seq #(.W(12), .D(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_v[2]), .bin(bin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd_s), .neg(neg_v[2]), .overflow(ovf_v[2])
    );

    function automatic logic [15:0] get_bcd(input int sel);
        if (sel == 0) return bcd_u;
        if (sel == 1) return {4'h0, bcd_o};
        return bcd_s;
    endfunction

    // Reference: decimal digits of |value| by division, sign from two's-complement reading.
    function automatic void model(input int sel, input logic [11:0] val,
                                  output logic [15:0] e_bcd, output logic e_neg, output logic e_ovf);
        int unsigned mag, r, lim;
        int digits;
        digits = (sel == 1) ? 3 : 4;
        if (sel == 2 && val[11]) begin
            mag   = 4096 - int'(val);
            e_neg = 1'b1;
        end else begin
            mag   = int'(val);
            e_neg = 1'b0;
        end
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e_ovf = (mag >= lim);
        e_bcd = '0;
        r = mag;
        for (int i = 0; i < digits; i++) begin
            e_bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    // Issue one request on instance sel (called #1 after a rising edge) and wait for done.
    // bin is scrambled right after acceptance; an optional second start is driven while busy.
    task automatic convert(input int sel, input logic [11:0] val, input int guard_n,
                           input logic [11:0] guard_val, output logic [15:0] g_bcd,
                           output logic g_neg, output logic g_ovf, output int lat);
        start_v[sel] = 1'b1;
        bin_v[sel]   = val;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        bin_v[sel]   = 12'($urandom);
        lat = -1;
        n_cmp++;
        if (busy_v[sel] !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_accept sel=%0d got=%b want=1", sel, busy_v[sel]);
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start_v[sel] = 1'b0;
            if (n == guard_n) begin
                start_v[sel] = 1'b1;
                bin_v[sel]   = guard_val;
            end
            if (busy_v[sel] === 1'b1 && done_v[sel] === 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL busy_and_done sel=%0d cycle=%0d", sel, n);
            end
            if (done_v[sel] === 1'b1) begin
                lat = n;
                break;
            end
        end
        start_v[sel] = 1'b0;
        g_bcd = get_bcd(sel);
        g_neg = neg_v[sel];
        g_ovf = ovf_v[sel];
        n_cmp++;
        if (lat == -1) begin
            n_bad++;
            $display("FAIL done_timeout sel=%0d val=%0d", sel, val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_v = '0;
        for (int s = 0; s < 3; s++) bin_v[s] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if ({busy_v[s], done_v[s], neg_v[s], ovf_v[s]} !== 4'b0 || get_bcd(s) !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_state sel=%0d got busy/done/neg/ovf=%b bcd=%h want 0", s,
                         {busy_v[s], done_v[s], neg_v[s], ovf_v[s]}, get_bcd(s));
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_max();
        logic [15:0] b; logic n, o; int lat;
        convert(0, 12'd4095, 0, 12'd0, b, n, o, lat);
        n_cmp++;
        if (lat != W || b !== 16'h4095 || o !== 1'b0 || n !== 1'b0) begin
            n_bad++;
            $display("FAIL max_value got lat=%0d bcd=%h ovf=%b neg=%b want lat=%0d bcd=4095 ovf=0 neg=0",
                     lat, b, o, n, W);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b; logic n, o; int lat;
        convert(0, 12'd0, 0, 12'd0, b, n, o, lat);
        n_cmp++;
        if (b !== 16'h0000 || lat != W) begin
            n_bad++;
            $display("FAIL zero got bcd=%h lat=%0d want bcd=0000 lat=%0d", b, lat, W);
        end
        // Still in the done cycle: this start must be accepted immediately.
        convert(0, 12'd1234, 0, 12'd0, b, n, o, lat);
        n_cmp++;
        if (b !== 16'h1234 || lat != W) begin
            n_bad++;
            $display("FAIL back_to_back got bcd=%h lat=%0d want bcd=1234 lat=%0d", b, lat, W);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bcd_u !== 16'h1234 || done_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL output_hold got bcd=%h done=%b want bcd=1234 done=0", bcd_u, done_v[0]);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] b; logic n, o; int lat;
        convert(1, 12'd1000, 0, 12'd0, b, n, o, lat);
        n_cmp++;
        if (o !== 1'b1 || b !== 16'h0000) begin
            n_bad++;
            $display("FAIL overflow_1000 got ovf=%b bcd=%h want ovf=1 bcd=000", o, b);
        end
        convert(1, 12'd999, 0, 12'd0, b, n, o, lat);
        n_cmp++;
        if (o !== 1'b0 || b !== 16'h0999) begin
            n_bad++;
            $display("FAIL overflow_999 got ovf=%b bcd=%h want ovf=0 bcd=999", o, b);
        end
    endtask

    task automatic test_signed();
        logic [11:0] vals [3];
        logic [15:0] want_b [3];
        logic        want_n [3];
        logic [15:0] b; logic n, o; int lat;
        vals[0] = 12'h800; want_b[0] = 16'h2048; want_n[0] = 1'b1;
        vals[1] = 12'hFFF; want_b[1] = 16'h0001; want_n[1] = 1'b1;
        vals[2] = 12'h7FF; want_b[2] = 16'h2047; want_n[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            convert(2, vals[i], 0, 12'd0, b, n, o, lat);
            n_cmp++;
            if (b !== want_b[i] || n !== want_n[i] || o !== 1'b0) begin
                n_bad++;
                $display("FAIL signed_%0d got bcd=%h neg=%b ovf=%b want bcd=%h neg=%b ovf=0",
                         i, b, n, o, want_b[i], want_n[i]);
            end
        end
    endtask

    task automatic test_busy_guard();
        logic [15:0] b; logic n, o; int lat;
        int extra;
        convert(0, 12'd77, 3, 12'd500, b, n, o, lat);
        n_cmp++;
        if (b !== 16'h0077 || lat != W) begin
            n_bad++;
            $display("FAIL busy_guard got bcd=%h lat=%0d want bcd=0077 lat=%0d", b, lat, W);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0 || bcd_u !== 16'h0077) begin
            n_bad++;
            $display("FAIL busy_guard_queued got extra_activity=%0d bcd=%h want 0 and 0077", extra, bcd_u);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] b; logic n, o; int lat;
        int seen;
        start_v[0] = 1'b1;
        bin_v[0]   = 12'd321;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy_v[0], done_v[0], neg_v[0], ovf_v[0]} !== 4'b0 || bcd_u !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_mid got busy/done/neg/ovf=%b bcd=%h want 0",
                     {busy_v[0], done_v[0], neg_v[0], ovf_v[0]}, bcd_u);
        end
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done_v[0] === 1'b1) seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done got activity=%0d want 0", seen);
        end
        convert(0, 12'd321, 0, 12'd0, b, n, o, lat);
        n_cmp++;
        if (b !== 16'h0321 || lat != W) begin
            n_bad++;
            $display("FAIL reset_mid_restart got bcd=%h lat=%0d want bcd=0321 lat=%0d", b, lat, W);
        end
    endtask

    task automatic test_random();
        logic [15:0] b, eb; logic n, o, en, eo; int lat;
        logic [11:0] v;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 15; i++) begin
                v = 12'($urandom);
                if (i == 0) v = 12'd0;
                model(s, v, eb, en, eo);
                convert(s, v, 0, 12'd0, b, n, o, lat);
                n_cmp++;
                if (b !== eb || n !== en || o !== eo || lat != W) begin
                    n_bad++;
                    $display("FAIL random sel=%0d bin=%h got bcd=%h neg=%b ovf=%b lat=%0d want bcd=%h neg=%b ovf=%b lat=%0d",
                             s, v, b, n, o, lat, eb, en, eo, W);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_overflow();
        test_signed();
        test_busy_guard();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
